// File: rtl/demux4_buf.sv
// 1-to-4 registered demultiplexer with a one-entry valid/ready register per lane.
// Optional DEMUX4_XFER_CNT_EN adds a wrapping count of accepted input words.
module demux4_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_select,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] xfer_count
);

  logic [3:0]       lane_free;
  logic             accept;
  logic [WIDTH-1:0] lane_data [4];

  // A lane can take a word if it is empty or being drained this same edge.
  assign lane_free = ~out_valid | out_ready;
  assign in_ready  = lane_free[in_select];
  assign accept    = in_valid & in_ready;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every lane sees the pre-edge values of out_valid/out_ready.
  // NOTE: the lane data registers are reset too, because the outputs must read
  // zero while rst_n is low rather than whatever was last stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) lane_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (in_select == 2'(i))) begin
          out_valid[i] <= 1'b1;
          lane_data[i] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];

`ifdef DEMUX4_XFER_CNT_EN
  logic [CNT_W-1:0] xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      xfer_cnt <= '0;
    else if (accept) xfer_cnt <= xfer_cnt + CNT_W'(1);
  end

  assign xfer_count = xfer_cnt;
`else
  assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Randomized and directed bench for demux4_buf against a lane-occupancy model.
// Build with or without +define+DEMUX4_XFER_CNT_EN; CNT_W is 4 to exercise wrap.
module tb_demux4_buf;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_select;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [CNT_W-1:0] xfer_count;

  demux4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_select  (in_select),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // Reference model: what each lane currently holds and how many words went in.
  bit         m_full [4];
  logic [31:0] m_data [4];
  int         m_accepted;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_count();
`ifdef DEMUX4_XFER_CNT_EN
    return 32'(m_accepted % (1 << CNT_W));
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] model_valid();
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = m_full[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
    end
    m_accepted = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(out_valid), model_valid());
    check({tag, ".d0"}, out_data0, m_data[0]);
    check({tag, ".d1"}, out_data1, m_data[1]);
    check({tag, ".d2"}, out_data2, m_data[2]);
    check({tag, ".d3"}, out_data3, m_data[3]);
    check({tag, ".cnt"}, 32'(xfer_count), exp_count());
  endtask

  // Called at a falling edge: drive one cycle of inputs, check in_ready, let the
  // rising edge happen, then compare every output at the next falling edge.
  task automatic step(input string tag, input bit v, input logic [1:0] sel,
                      input logic [31:0] d, input logic [3:0] rdy, output bit acc);
    bit can_take;
    in_valid  = v;
    in_select = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
    can_take = !m_full[sel] || rdy[sel];
    check({tag, ".in_ready"}, 32'(in_ready), 32'(can_take));
    acc = v && can_take;
    // Consumers take whatever they were ready for, then the new word lands.
    for (int i = 0; i < 4; i++) if (rdy[i]) m_full[i] = 1'b0;
    if (acc) begin
      m_full[sel] = 1'b1;
      m_data[sel] = d;
      m_accepted++;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  bit acc;
  bit pend;
  logic [1:0]  p_sel;
  logic [31:0] p_data;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_select = 2'b00;
    in_data   = '0;
    out_ready = 4'b0000;
    model_clear();

    // Reset / idle: every lane is free regardless of select.
    #1;
    check_outputs("reset");
    for (int s = 0; s < 4; s++) begin
      in_select = 2'(s);
      #1;
      check($sformatf("reset.in_ready%0d", s), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single route to lane 2, drained the following cycle.
    step("route", 1'b1, 2'b10, 32'hDEADBEEF, 4'b0100, acc);
    check("route.v", 32'(out_valid), 32'h4);
    check("route.d2", out_data2, 32'hDEADBEEF);
    step("route_drain", 1'b0, 2'b10, 32'h0, 4'b0100, acc);
    check("route_drain.v", 32'(out_valid), 32'h0);

    // Backpressure on lane 1; the held word goes in once lane 1 drains.
    step("bp_fill", 1'b1, 2'b01, 32'h11, 4'b0000, acc);
    step("bp_stall0", 1'b1, 2'b01, 32'h22, 4'b0000, acc);
    check("bp_stall0.acc", 32'(acc), 32'd0);
    step("bp_stall1", 1'b1, 2'b01, 32'h22, 4'b0000, acc);
    check("bp_stall1.d1", out_data1, 32'h11);
    step("bp_release", 1'b1, 2'b01, 32'h22, 4'b0010, acc);
    check("bp_release.d1", out_data1, 32'h22);
    check("bp_release.v1", 32'(out_valid[1]), 32'd1);
    step("bp_lane3", 1'b1, 2'b11, 32'h33, 4'b0000, acc);
    check("bp_lane3.d3", out_data3, 32'h33);
    step("bp_flush", 1'b0, 2'b00, 32'h0, 4'b1111, acc);

    // Streaming: eight words, one per cycle, no bubbles.
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("stream%0d", k), 1'b1, 2'(k - 1), 32'(k), 4'b1111, acc);
      check($sformatf("stream%0d.acc", k), 32'(acc), 32'd1);
    end
    step("stream_idle", 1'b0, 2'b00, 32'h0, 4'b1111, acc);

    // Asynchronous reset in the middle of a cycle with lanes 0 and 2 full.
    step("ar_fill0", 1'b1, 2'b00, 32'hA0, 4'b0000, acc);
    step("ar_fill2", 1'b1, 2'b10, 32'hA2, 4'b0000, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Counter wrap: 17 accepted words from a fresh reset.
    for (int k = 0; k < 17; k++)
      step($sformatf("cnt%0d", k), 1'b1, 2'($urandom_range(0, 3)), $urandom, 4'b1111, acc);
`ifdef DEMUX4_XFER_CNT_EN
    check("cnt_wrap", 32'(xfer_count), 32'd1);
`else
    check("cnt_off", 32'(xfer_count), 32'd0);
`endif

    // Random traffic; a refused word is held until it is taken.
    pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bit          v;
      logic [1:0]  sel;
      logic [31:0] d;
      if (pend) begin
        v = 1'b1;
        sel = p_sel;
        d = p_data;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        sel = 2'($urandom_range(0, 3));
        d = $urandom;
      end
      step("rand", v, sel, d, 4'($urandom), acc);
      pend   = v && !acc;
      p_sel  = sel;
      p_data = d;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
